// File: rtl/move_arbiter.sv
// move_arbiter: debounces BtnU/D/L/R and issues round-robin moves to block_controller.
// Define MOVE_AUTOREPEAT_EN to emit repeated moves while a button stays held.
module move_arbiter #(
    parameter int DB_CYCLES     = 1000000,
    parameter int DB_W          = 20,
    parameter int REPEAT_CYCLES = 30000000,
    parameter int RPT_W         = 25
) (
    input  logic       ClkPort,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    input  logic       move_done,
    output logic       busy,
    output logic [3:0] pending,
    output logic [7:0] dropped_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [3:0]      btn_raw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      stable;
    logic [3:0]      stable_d;
    logic [DB_W-1:0] db_cnt [4];
    logic [3:0]      press_evt;
    logic [3:0]      rpt_evt;
    logic [3:0]      event_v;
    logic [3:0]      grant_clr;
    logic [3:0]      drop_v;
    logic [2:0]      drop_num;
    logic [8:0]      drop_sum;
    logic [1:0]      last_grant;
    logic [1:0]      last_nx;
    logic [1:0]      dir_nx;
    logic [1:0]      arb_dir;
    logic [1:0]      idx;
    logic            arb_found;
    state_t          state;
    state_t          state_nx;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    always_ff @(posedge ClkPort or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge ClkPort or negedge rst_n) begin
        if (!rst_n) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press_evt = stable & ~stable_d;

`ifdef MOVE_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES);

    logic [RPT_W-1:0] rpt_cnt [4];

    // Counter equals the cycles since the real press; reload to 1 keeps the period exact.
    always_ff @(posedge ClkPort or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rpt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!stable[i])
                    rpt_cnt[i] <= '0;
                else if (rpt_cnt[i] == RPT_LAST)
                    rpt_cnt[i] <= RPT_W'(1);
                else
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rpt_evt = '0;
        for (int i = 0; i < 4; i++)
            rpt_evt[i] = stable[i] && (rpt_cnt[i] == RPT_LAST);
    end
`else
    // Repeat disabled; the expression is constant zero for any legal parameters.
    assign rpt_evt = {4{(REPEAT_CYCLES < 0) && (RPT_W < 0)}};
`endif

    assign event_v = press_evt | rpt_evt;

    always_comb begin
        grant_clr = '0;
        if (move_valid && move_ready) grant_clr[move_dir] = 1'b1;
    end

    assign drop_v   = event_v & pending & ~grant_clr;
    assign drop_num = 3'(drop_v[0]) + 3'(drop_v[1])
                    + 3'(drop_v[2]) + 3'(drop_v[3]);
    assign drop_sum = {1'b0, dropped_cnt} + {6'd0, drop_num};

    always_ff @(posedge ClkPort or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            dropped_cnt <= '0;
        end else begin
            pending     <= (pending & ~grant_clr) | event_v;
            dropped_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_comb begin
        arb_dir   = last_grant + 2'd1;
        arb_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < 4; k++) begin
            idx = last_grant + 2'd1 + 2'(k);
            if (!arb_found && pending[idx]) begin
                arb_dir   = idx;
                arb_found = 1'b1;
            end
        end
    end

    always_ff @(posedge ClkPort or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            move_dir   <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_nx;
            move_dir   <= dir_nx;
            last_grant <= last_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        dir_nx     = move_dir;
        last_nx    = last_grant;
        move_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    dir_nx   = arb_dir;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                move_valid = 1'b1;
                if (move_ready) begin
                    last_nx  = move_dir;
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (move_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Converts the four raw direction buttons into single, debounced move commands for the 2048 game logic (block_controller).
- Arbitrates between simultaneous or back-to-back presses using round-robin order.
- Issues one move at a time over a valid/ready handshake, then holds off until the game logic reports the move done.
- Sits in vga_top, between the BtnU/BtnD/BtnL/BtnR pins and block_controller.

Parameters:
- DB_CYCLES, 1000000, debounce settle time in clocks (10 ms at 100 MHz).
- DB_W, 20, debounce counter width; must satisfy 2^DB_W > DB_CYCLES.
- REPEAT_CYCLES, 30000000, auto-repeat interval in clocks; used only with MOVE_AUTOREPEAT_EN.
- RPT_W, 25, repeat counter width.

Ports:
- ClkPort  input  1  system clock, 100 MHz.
- rst_n  input  1  reset; asynchronous assert, active-low.
- btn_up, btn_down, btn_left, btn_right  input  1 each  raw, asynchronous, active-high buttons.
- move_valid  output  1  move command valid.
- move_dir  output  2  move direction: 00 up, 01 down, 10 left, 11 right.
- move_ready  input  1  game logic accepts the command.
- move_done  input  1  one-cycle pulse: game logic has finished the accepted move.
- busy  output  1  high whenever state != IDLE.
- pending  output  4  queued presses; bit0 up, bit1 down, bit2 left, bit3 right.
- dropped_cnt  output  8  count of presses lost; saturates at 255.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All flops clear.
  - move_valid=0, move_dir=00, busy=0, pending=0, dropped_cnt=0.
  - Round-robin pointer last_grant=3, so the first priority order is up, down, left, right.
  - Reset in any state drops move_valid immediately and discards all pending presses.
- Synchronizer: 2-FF per button, reset to 0.
- Debounce, per button:
  - Counter clears whenever sync == stable.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 with sync still != stable, stable <= sync and the counter clears.
  - Any glitch shorter than DB_CYCLES produces no change in stable.
- Press event: one-cycle pulse on stable 0->1.
- Pending, per direction i:
  - Set on a press event for i.
  - Cleared in the cycle the handshake completes (move_valid & move_ready & move_dir==i).
  - Set and clear in the same cycle: set wins.
  - Press event while pending[i] is already 1 and not being cleared: press is dropped; dropped_cnt += 1, saturating at 255.
- Arbiter: round-robin over pending, searching from (last_grant+1) mod 4 upward with wrap. last_grant updates on handshake completion.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE: if pending != 0, register move_dir <= arbiter choice and go to ISSUE.
  - ISSUE:
    - move_valid=1; move_dir held constant.
    - On move_ready=1: clear pending[move_dir], set last_grant, go to WAIT_DONE. move_valid=0 from the next cycle.
  - WAIT_DONE: on move_done=1 go to IDLE.
  - move_done in IDLE or ISSUE is ignored.
- Latency:
  - Press-event pulse in cycle t -> pending visible at t+1 -> move_valid=1 at t+2.
  - Minimum gap from move_done to the next move_valid: 2 cycles (IDLE evaluates, then ISSUE).
- Simultaneous press events on several buttons in one cycle: all are set pending; they are granted one per handshake in round-robin order.
- Counters and pointer wrap mod 4; dropped_cnt never wraps.

Optional Feature:
- Macro: MOVE_AUTOREPEAT_EN.
- Defined:
  - While stable[i] stays 1, a per-button repeat counter runs. It generates a synthetic press event REPEAT_CYCLES cycles after the real press event, then every REPEAT_CYCLES cycles after that.
  - Synthetic events follow the same pending/drop rules as real ones.
  - The counter clears when stable[i] goes to 0.
- Not defined: only real 0->1 edges generate events. The repeat logic is absent; REPEAT_CYCLES and RPT_W are unused.

Test Plan (DB_CYCLES=4, REPEAT_CYCLES=16, move_ready tied 1 unless stated):
- Reset: hold rst_n=0 with all buttons high -> move_valid=0, pending=0, dropped_cnt=0. Release -> after sync and debounce, exactly one move per button.
- Debounce: btn_up toggles every 2 cycles for 20 cycles, then stays 0 -> no move_valid. Then held 1 -> exactly one move_valid with move_dir=00, held for one cycle; the second move_valid appears only after a new 0->1 edge.
- Simultaneous, from reset: btn_left and btn_right rise in the same cycle -> first grant move_dir=10, second 11. Second move_valid rises 2 cycles after the move_done pulse.
- Round-robin: after an up grant, up and right pending together -> right (11) granted before up (00).
- Backpressure and drop: move_ready=0 for 50 cycles -> move_valid stays 1 with move_dir constant. Re-pressing the same button during this -> dropped_cnt=1, and pending[dir] stays 1 until move_ready=1.
- Reset mid-ISSUE: assert rst_n=0 while move_valid=1 -> move_valid=0 asynchronously, pending=0, busy=0. With MOVE_AUTOREPEAT_EN, holding btn_down for 40 cycles after debounce -> moves at press, +16 and +32 cycles, each after the previous move_done.
